seg7_scan_driver: RTL

//   Downstream display stage for the two-digit BCD counter (ones/tens nibbles).

---
 rtl/seg7_scan_driver.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver.
// A BCD digit pair is accepted over a valid/ready handshake into a shadow
// register. The pair is copied into the display register only when the scan
// enters a guard interval, so a lit digit never changes mid-interval.
// Scan order: GUARD_O -> ONES -> GUARD_T -> TENS -> GUARD_O.
//
// Handshake: a transfer happens on a rising edge where din_valid && din_ready.
// din_ready is simply !pending. It drops on the cycle after a transfer and
// returns on the cycle after the pending pair is applied. Data offered while
// din_ready is low is ignored. din_valid may drop at any time.
module seg7_scan_driver #(
    parameter int SCAN_DIV        = 50000,
    parameter int GUARD           = 4,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit AN_ACTIVE_LOW   = 1'b1,
    parameter bit BLANK_LEAD_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din_valid,
    input  logic [3:0] din_ones,
    input  logic [3:0] din_tens,
    output logic       din_ready,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       digit_err
);

    // The divider is sized for the longer of the two interval lengths.
    // A width of at least one bit is kept so the vector stays legal when
    // both lengths are 1.
    localparam int MAX_LEN = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0] DIV_ONE    = CW'(1);

    // The "all dark" output levels follow the configured polarities.
    // The same masks convert lit/enabled bits into pin levels.
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_OFF  = {2{AN_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        GUARD_O = 2'd0,
        ONES    = 2'd1,
        GUARD_T = 2'd2,
        TENS    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] div;
    logic [CW-1:0] div_next;

    logic          pending;
    logic [3:0]    shadow_ones;
    logic [3:0]    shadow_tens;
    logic [3:0]    disp_ones;
    logic [3:0]    disp_tens;

    logic          enter_guard;
    logic          apply_now;
    logic          take_now;

    logic [6:0]    lit_next;
    logic [1:0]    an_on_next;
    logic [6:0]    seg_next;
    logic [1:0]    an_next;

    // Segment pattern for one nibble. Bit 0 is segment a and bit 6 is
    // segment g; a 1 means the segment is lit. Non-BCD nibbles show a
    // lone dash (segment g).
    function automatic logic [6:0] enc_lit(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'd0:    r = 7'b0111111;
            4'd1:    r = 7'b0000110;
            4'd2:    r = 7'b1011011;
            4'd3:    r = 7'b1001111;
            4'd4:    r = 7'b1100110;
            4'd5:    r = 7'b1101101;
            4'd6:    r = 7'b1111101;
            4'd7:    r = 7'b0000111;
            4'd8:    r = 7'b1111111;
            4'd9:    r = 7'b1101111;
            default: r = 7'b1000000;
        endcase
        return r;
    endfunction

    // A nibble above 9 is not a BCD digit.
    function automatic logic is_bad(input logic [3:0] v);
        return (v > 4'd9);
    endfunction

    // Scan sequencing. One divider serves every interval: it counts from 0
    // to the interval length minus 1, then wraps to 0 as the state advances.
    always_comb begin
        state_next = state;
        div_next   = div + DIV_ONE;
        case (state)
            GUARD_O: begin
                if (div == GUARD_LAST) begin
                    state_next = ONES;
                    div_next   = '0;
                end
            end
            ONES: begin
                if (div == SCAN_LAST) begin
                    state_next = GUARD_T;
                    div_next   = '0;
                end
            end
            GUARD_T: begin
                if (div == GUARD_LAST) begin
                    state_next = TENS;
                    div_next   = '0;
                end
            end
            TENS: begin
                if (div == SCAN_LAST) begin
                    state_next = GUARD_O;
                    div_next   = '0;
                end
            end
            default: begin
                state_next = GUARD_O;
                div_next   = '0;
            end
        endcase
    end

    // Scan state and divider registers. Reset always restarts the scan at
    // the start of the ones guard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GUARD_O;
            div   <= '0;
        end else begin
            state <= state_next;
            div   <= div_next;
        end
    end

    // Every interval is at least one cycle long, so the state changes only
    // on a wrap. The edge that enters either guard is the digit boundary.
    assign enter_guard = (state_next != state) &&
                         ((state_next == GUARD_O) || (state_next == GUARD_T));
    assign apply_now   = enter_guard && pending;
    assign take_now    = din_valid && !pending;
    assign din_ready   = !pending;

    // Capture into the shadow register and apply it at the next digit
    // boundary. Capture needs pending low and apply needs it high, so the
    // two never fall on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            shadow_ones <= 4'd0;
            shadow_tens <= 4'd0;
            disp_ones   <= 4'd0;
            disp_tens   <= 4'd0;
            digit_err   <= 1'b0;
        end else if (apply_now) begin
            disp_ones <= shadow_ones;
            disp_tens <= shadow_tens;
            pending   <= 1'b0;
            digit_err <= is_bad(shadow_ones) || is_bad(shadow_tens);
        end else if (take_now) begin
            shadow_ones <= din_ones;
            shadow_tens <= din_tens;
            pending     <= 1'b1;
        end
    end

    // Output values for the state being entered. Decoding from state_next
    // lets the registered pins change on the same edge as the state. The
    // display register does not change on entry to ONES or TENS, so it can
    // be read directly here.
    always_comb begin
        lit_next   = 7'd0;
        an_on_next = 2'b00;
        case (state_next)
            ONES: begin
                an_on_next = 2'b01;
                lit_next   = enc_lit(disp_ones);
            end
            TENS: begin
                // Only an exact zero is blanked. An invalid tens nibble
                // still shows its dash.
                if (!(BLANK_LEAD_ZERO && (disp_tens == 4'd0))) begin
                    an_on_next = 2'b10;
                    lit_next   = enc_lit(disp_tens);
                end
            end
            default: begin
                an_on_next = 2'b00;
                lit_next   = 7'd0;
            end
        endcase
        seg_next = lit_next ^ SEG_OFF;
        an_next  = an_on_next ^ AN_OFF;
    end

    // Segment and anode registers. All segments and anodes are dark while
    // reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
